// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type, length constants and length decode for the fetch stage
package fetch_pkg;

   localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

   localparam logic [1:0] LEN_1 = 2'd1;
   localparam logic [1:0] LEN_2 = 2'd2;
   localparam logic [1:0] LEN_3 = 2'd3;

   typedef enum logic [2:0] {
      FETCH_OP,
      FETCH_LO,
      FETCH_HI,
      HOLD,
      DRAIN
   } state_t;

   // Instruction length is carried entirely by the top two opcode bits.
   function automatic logic [1:0] decode_len(input logic [1:0] op_class);
      case (op_class)
         2'b00:   decode_len = LEN_1;
         2'b01:   decode_len = LEN_2;
         default: decode_len = LEN_3;
      endcase
   endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// rtl/fetch_len_decode.sv - combinational opcode to instruction length decode
module fetch_len_decode
   import fetch_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] len
);

   logic unused_low_bits;

   assign len             = decode_len(opcode[7:6]);
   assign unused_low_bits = ^opcode[5:0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC, walks the byte bus, hands bundles to decode
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_value,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        instr_opcode,
   output logic [15:0]       instr_operand,
   output logic [1:0]        instr_len,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_out
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
   logic [ADDR_W-1:0] target, target_nxt;
   logic [ADDR_W-1:0] op_pc, op_pc_nxt;
   logic [7:0]        opcode, opcode_nxt;
   logic [15:0]       operand, operand_nxt;
   logic [1:0]        len, len_nxt, rdata_len;
   logic              fetching;

   fetch_len_decode u_len_decode (
      .opcode (mem_rdata),
      .len    (rdata_len)
   );

   assign fetching = (state == FETCH_OP) || (state == FETCH_LO) || (state == FETCH_HI);
   // Gated by rst_n so the request drops the moment reset asserts, not at the next edge.
   assign mem_req  = rst_n && (fetching || (state == DRAIN));
   assign pc_inc   = pc + ADDR_W'(1);

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      target_nxt  = target;
      op_pc_nxt   = op_pc;
      opcode_nxt  = opcode;
      operand_nxt = operand;
      len_nxt     = len;
      case (state)
         FETCH_OP, FETCH_LO, FETCH_HI: begin
            if (pc_load && !mem_ack) begin
               // Bus cycle already in flight: finish it in DRAIN, then redirect.
               target_nxt = pc_load_value;
               state_nxt  = DRAIN;
            end else if (pc_load) begin
               pc_nxt    = pc_load_value;
               state_nxt = FETCH_OP;
            end else if (mem_ack) begin
               pc_nxt = pc_inc;
               case (state)
                  FETCH_OP: begin
                     opcode_nxt  = mem_rdata;
                     op_pc_nxt   = pc;
                     operand_nxt = '0;
                     len_nxt     = rdata_len;
                     state_nxt   = (rdata_len == LEN_1) ? HOLD : FETCH_LO;
                  end
                  FETCH_LO: begin
                     operand_nxt[7:0] = mem_rdata;
                     state_nxt        = (len == LEN_2) ? HOLD : FETCH_HI;
                  end
                  default: begin
                     operand_nxt[15:8] = mem_rdata;
                     state_nxt         = HOLD;
                  end
               endcase
            end
         end
         HOLD: begin
            if (pc_load) begin
               pc_nxt    = pc_load_value;
               state_nxt = FETCH_OP;
            end else if (instr_ready) begin
               state_nxt = FETCH_OP;
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               pc_nxt    = pc_load ? pc_load_value : target;
               state_nxt = FETCH_OP;
            end else if (pc_load) begin
               target_nxt = pc_load_value;
            end
         end
         default: state_nxt = FETCH_OP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH_OP;
         pc      <= RESET_VECTOR;
         target  <= '0;
         op_pc   <= '0;
         opcode  <= '0;
         operand <= '0;
         len     <= '0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         target  <= target_nxt;
         op_pc   <= op_pc_nxt;
         opcode  <= opcode_nxt;
         operand <= operand_nxt;
         len     <= len_nxt;
      end
   end

   assign mem_addr      = pc;
   assign pc_out        = pc;
   assign instr_valid   = (state == HOLD);
   assign instr_opcode  = opcode;
   assign instr_operand = operand;
   assign instr_len     = len;
   assign instr_pc      = op_pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that owns the 16-bit program counter and walks the byte-wide memory bus.
- Fetches 1–3 byte instructions (opcode, operand low, operand high) and presents them to the decoder through a valid/ready handshake.
- Consumes the +1 increment of the PC each byte.
- Accepts a jump/branch PC load from the execute stage.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, address/PC width. Fixed at 16; the parameter documents the width only.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  out  16  byte address of current fetch
- mem_req  out  1  fetch request; held until mem_ack
- mem_ack  in  1  read data valid this cycle; may coincide with the first mem_req cycle
- mem_rdata  in  8  read data, sampled when mem_req && mem_ack
- pc_load  in  1  one-cycle request to redirect fetch
- pc_load_value  in  16  redirect target
- instr_valid  out  1  instruction bundle valid
- instr_ready  in  1  decoder accepts bundle
- instr_opcode  out  8  opcode byte
- instr_operand  out  16  {hi, lo}; unfetched bytes read as 0
- instr_len  out  2  1, 2 or 3
- instr_pc  out  16  address of the opcode byte
- pc_out  out  16  current PC (next byte to fetch)

Behaviour:
- Reset (async, rst_n=0): PC=RESET_VECTOR; state=FETCH_OP; mem_req=0 while in reset; instr_valid=0; opcode, operand, len, instr_pc = 0.
- mem_req=1 in every FETCH_* state; mem_addr=PC.
- States: FETCH_OP, FETCH_LO, FETCH_HI, HOLD, DRAIN.
- Length decode from opcode[7:6]: 00 → 1; 01 → 2; 10 or 11 → 3.
- FETCH_OP on ack:
  - latch opcode; instr_pc=PC; PC=PC+1.
  - clear operand.
  - go to HOLD if len=1, else FETCH_LO.
- FETCH_LO on ack: operand[7:0]=rdata; PC+1. Go to HOLD if len=2, else FETCH_HI.
- FETCH_HI on ack: operand[15:8]=rdata; PC+1. Go to HOLD.
- HOLD:
  - instr_valid=1 and bundle stable until instr_valid && instr_ready.
  - On transfer, go to FETCH_OP next cycle.
  - Zero-wait memory gives 1-byte throughput of one instruction per 2 cycles.
- PC arithmetic: modulo 2^16; 16'hFFFF+1 = 16'h0000. An instruction may straddle the wrap.
- pc_load:
  - In HOLD or in a FETCH_* state with mem_ack=1 the same cycle: PC=pc_load_value, go to FETCH_OP.
  - Any partially assembled or held instruction is discarded; instr_valid drops next cycle.
  - pc_load wins over instr_ready in the same cycle; the bundle counts as not transferred.
  - In a FETCH_* state with mem_ack=0: the bus transaction must not be abandoned. Latch the target, go to DRAIN and keep mem_req=1 with the old mem_addr.
  - On ack in DRAIN: discard rdata, PC=latched target, go to FETCH_OP.
  - A second pc_load while in DRAIN overwrites the latched target.
- Reset mid-transaction: everything returns to reset values immediately, including mem_req=0. The memory side tolerates this.
- instr_ready outside HOLD is ignored. mem_ack with mem_req=0 is ignored.

Decomposition:
- Package fetch_pkg holds:
  - state enum (FETCH_OP, FETCH_LO, FETCH_HI, HOLD, DRAIN)
  - instruction-length constants
  - length-decode function of opcode[7:6]
  - default reset vector
- One sub-module, fetch_len_decode (opcode → len). It is combinational; the execute stage reuses it.
- The PC incrementer stays inline.

Test Plan:
- Reset, zero-wait memory; mem[0]=8'h05 (len 1), then release rst_n → mem_addr 0000, then 0001. Bundle: opcode 05, operand 0000, len 1, instr_pc 0000, instr_valid at cycle 1. With instr_ready=1, next mem_req is at cycle 2.
- Bytes 8'h8A,8'h34,8'h12 at 0x0010 via pc_load=0x0010 → bundle: opcode 8A, operand 1234, len 3, instr_pc 0010; pc_out 0013.
- Hold with instr_ready=0 for 5 cycles → bundle and instr_valid stable; mem_req=0 throughout.
- 2-byte opcode 8'h41 at FFFF, operand 8'h77 at 0000 → mem_addr FFFF then 0000; operand 0077; pc_out 0001.
- pc_load=0x2000 in FETCH_LO while mem_ack held low 3 cycles → mem_addr unchanged and mem_req kept until ack; rdata discarded; next mem_addr 2000; no instr_valid for the aborted instruction.
- Assert rst_n=0 mid FETCH_HI → mem_req, instr_valid and pc_out (=RESET_VECTOR) change asynchronously before the next clk edge.
